riscv_dm_axil_sri_bridge: RTL and testbench
===========================================

# riscv_dm_axil_sri_bridge

AXI4-Lite slave to SRI master bridge placed directly upstream of the debug module's SRI port. It serialises AXI4-Lite reads and writes from the SoC interconnect into single-beat SRI accesses to the program/data buffers and returns the SRI read data and error as AXI responses. Only one transaction is in flight at a time.

## Interface
- AXI_ADDR_WIDTH, 20: AXI byte-address width.
- AXI_DATA_WIDTH, 64: AXI data width. Fixed at 64, equal to the SRI data width; any other value is an elaboration error.
- SRI_ADDR_WIDTH, 6: SRI byte-address width, equal to the debug module's SRI ADDR_WIDTH.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
- clk_i  in  1  Clock; all logic is rising-edge.
- rstn_i  in  1  Asynchronous active-low reset.
- s_awaddr_i  in  AXI_ADDR_WIDTH  Write address.
- s_awvalid_i / s_awready_o  in/out  1  AW handshake.
- s_wdata_i  in  64  Write data.
- s_wstrb_i  in  8  Write byte strobes.
- s_wvalid_i / s_wready_o  in/out  1  W handshake.
- s_bresp_o  out  2  Write response.
- s_bvalid_o / s_bready_i  out/in  1  B handshake.
- s_araddr_i  in  AXI_ADDR_WIDTH  Read address.
- s_arvalid_i / s_arready_o  in/out  1  AR handshake.
- s_rdata_o  out  64  Read data.
- s_rresp_o  out  2  Read response.
- s_rvalid_o / s_rready_i  out/in  1  R handshake.
- sri_addr_o  out  SRI_ADDR_WIDTH  SRI byte address.
- sri_en_o  out  1  SRI access strobe, one cycle per access.
- sri_we_o  out  1  SRI write enable.
- sri_wdata_o  out  64  SRI write data.
- sri_be_o  out  8  SRI byte enables.
- sri_rdata_i  in  64  SRI read data.
- sri_error_i  in  1  SRI access error.

## Operation
- FSM states:
  - IDLE: waits for a request.
  - ACCESS: drives `sri_en_o` for exactly one cycle.
  - CAPTURE: samples `sri_rdata_i` and `sri_error_i`.
  - BRESP: holds `s_bvalid_o` until `s_bready_i`.
  - RRESP: holds `s_rvalid_o` until `s_rready_i`.
- Write request: exists only when `s_awvalid_i` and `s_wvalid_i` are both high. AW and W are always accepted in the same cycle; `s_awready_o = s_wready_o`.
- Read request: exists when `s_arvalid_i` is high.
- Ready signals in IDLE are combinational from the valids and the grant. They are 0 in every other state.
- Arbitration when a write and a read request are present together in IDLE:
  - Round-robin: the type not granted last wins.
  - A 1-bit `last_was_write` register resets to 1, so the first collision grants the read.
- On handshake, latch the following; SRI outputs are driven only from these registers:
  - address[SRI_ADDR_WIDTH-1:0]
  - wdata and wstrb
  - the type bit
- ACCESS: `sri_en_o = 1`; `sri_we_o` = type bit; `sri_be_o` = strobes for a write, 8'hFF for a read.
- CAPTURE:
  - Register `resp = sri_error_i ? 2'b10 (SLVERR) : 2'b00 (OKAY)`.
  - For a read, register `s_rdata_o = sri_rdata_i`. Read data is passed through even on SLVERR.
  - Then go to BRESP or RRESP.
- BRESP/RRESP: return to IDLE in the cycle after the response handshake completes. Response outputs stay stable while valid is high and ready is low.
- `s_wstrb_i == 0` is still issued to SRI with `sri_be_o = 0`.

## Timing
- Reset values: all ready and valid outputs 0; `sri_en_o`, `sri_we_o` 0; `sri_addr_o`, `sri_wdata_o`, `sri_be_o`, `s_rdata_o` 0; `s_bresp_o`, `s_rresp_o` 2'b00; state IDLE.
- Latency, with handshake at cycle T:
  - `sri_en_o` high at T+1.
  - SRI response sampled at T+2.
  - `s_bvalid_o`/`s_rvalid_o` high from T+3.
- With ready held high, throughput is one transaction per 4 cycles.
- SRI contract: response is valid in the cycle after `sri_en_o`, for both reads and writes.
- Reset asserted mid-transaction: the transaction is abandoned; all outputs go to reset values immediately (asynchronously); no response is issued.

## Configuration
- `RISCV_DM_AXIL_DECERR_EN` defined:
  - A request with any nonzero address bit in [AXI_ADDR_WIDTH-1:SRI_ADDR_WIDTH] skips ACCESS and CAPTURE, so `sri_en_o` is never asserted for it.
  - Response is 2'b11 (DECERR), valid at T+1; read data is 0.
- Undefined: upper address bits are ignored and the SRI window aliases across the whole AXI space.

## Test plan
- Write awaddr 0x00008, wdata 0x1122334455667788, wstrb 0x0F, bready=1 -> at T+1 `sri_en_o=1`, `sri_we_o=1`, `sri_addr_o=0x08`, `sri_be_o=0x0F`; `s_bvalid_o=1` at T+3 with bresp OKAY.
- Read araddr 0x00010 with SRI returning 0xDEADBEEF00000001 at T+2 -> `s_rvalid_o` at T+3 with that data and rresp OKAY. Hold `s_rready_i=0` for 5 cycles -> data stable; state returns to IDLE one cycle after the handshake.
- `sri_error_i=1` during CAPTURE on a write -> bresp 2'b10.
- AR, AW and W all valid in IDLE after reset -> read granted first, then write; the next collision grants the read again only after a write has been granted.
- With the macro defined, araddr 0x00400 -> no `sri_en_o`, rvalid at T+1 with rresp 2'b11 and rdata 0. With the macro undefined, the same access hits SRI address 0x00.
- `rstn_i` pulsed low during ACCESS -> `sri_en_o` drops immediately; no B or R response; the next write completes normally.

Source files
------------

// File: rtl/riscv_dm_axil_sri_bridge.sv
// rtl/riscv_dm_axil_sri_bridge.sv - AXI4-Lite slave to single-beat SRI master bridge for the debug module.
// Optional decode error on upper address bits: define RISCV_DM_AXIL_DECERR_EN.
module riscv_dm_axil_sri_bridge #(
  parameter int AXI_ADDR_WIDTH = 20,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int SRI_ADDR_WIDTH = 6
) (
  input  logic                        clk_i,
  input  logic                        rstn_i,
  input  logic [AXI_ADDR_WIDTH-1:0]   s_awaddr_i,
  input  logic                        s_awvalid_i,
  output logic                        s_awready_o,
  input  logic [AXI_DATA_WIDTH-1:0]   s_wdata_i,
  input  logic [AXI_DATA_WIDTH/8-1:0] s_wstrb_i,
  input  logic                        s_wvalid_i,
  output logic                        s_wready_o,
  output logic [1:0]                  s_bresp_o,
  output logic                        s_bvalid_o,
  input  logic                        s_bready_i,
  input  logic [AXI_ADDR_WIDTH-1:0]   s_araddr_i,
  input  logic                        s_arvalid_i,
  output logic                        s_arready_o,
  output logic [AXI_DATA_WIDTH-1:0]   s_rdata_o,
  output logic [1:0]                  s_rresp_o,
  output logic                        s_rvalid_o,
  input  logic                        s_rready_i,
  output logic [SRI_ADDR_WIDTH-1:0]   sri_addr_o,
  output logic                        sri_en_o,
  output logic                        sri_we_o,
  output logic [63:0]                 sri_wdata_o,
  output logic [7:0]                  sri_be_o,
  input  logic [63:0]                 sri_rdata_i,
  input  logic                        sri_error_i
);

  if (AXI_DATA_WIDTH != 64) begin : g_bad_data_width
    $error("riscv_dm_axil_sri_bridge: AXI_DATA_WIDTH must be 64");
  end

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ACCESS  = 3'd1,
    CAPTURE = 3'd2,
    BRESP   = 3'd3,
    RRESP   = 3'd4
  } state_t;

  state_t                    state_q, state_d;
  logic                      last_was_write_q;
  logic                      type_q;
  logic [SRI_ADDR_WIDTH-1:0] addr_q;
  logic [63:0]               wdata_q;
  logic [7:0]                be_q;
  logic [1:0]                resp_q;
  logic [63:0]               rdata_q;

  logic                      wr_req, rd_req, grant_wr, grant_rd, hs;
  logic [AXI_ADDR_WIDTH-1:0] req_addr;
  logic                      req_oob;

  // On a collision the type not granted last wins.
  assign wr_req   = s_awvalid_i & s_wvalid_i;
  assign rd_req   = s_arvalid_i;
  assign grant_wr = (state_q == IDLE) & wr_req & (~rd_req | ~last_was_write_q);
  assign grant_rd = (state_q == IDLE) & rd_req & (~wr_req | last_was_write_q);
  assign hs       = grant_wr | grant_rd;
  assign req_addr = grant_wr ? s_awaddr_i : s_araddr_i;

`ifdef RISCV_DM_AXIL_DECERR_EN
  assign req_oob = |req_addr[AXI_ADDR_WIDTH-1:SRI_ADDR_WIDTH];
`else
  logic unused_upper_addr;
  assign unused_upper_addr = ^req_addr[AXI_ADDR_WIDTH-1:SRI_ADDR_WIDTH];
  assign req_oob = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (hs) begin
          if (req_oob) state_d = grant_wr ? BRESP : RRESP;
          else         state_d = ACCESS;
        end
      end
      ACCESS:  state_d = CAPTURE;
      CAPTURE: state_d = type_q ? BRESP : RRESP;
      BRESP:   if (s_bready_i) state_d = IDLE;
      RRESP:   if (s_rready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s_awready_o = grant_wr;
    s_wready_o  = grant_wr;
    s_arready_o = grant_rd;
    sri_en_o    = (state_q == ACCESS);
    sri_we_o    = (state_q == ACCESS) & type_q;
    s_bvalid_o  = (state_q == BRESP);
    s_rvalid_o  = (state_q == RRESP);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      last_was_write_q <= 1'b1;
      type_q           <= 1'b0;
      addr_q           <= '0;
      wdata_q          <= '0;
      be_q             <= '0;
      resp_q           <= 2'b00;
      rdata_q          <= '0;
    end else begin
      if (hs) begin
        last_was_write_q <= grant_wr;
        type_q           <= grant_wr;
        addr_q           <= req_addr[SRI_ADDR_WIDTH-1:0];
        be_q             <= grant_wr ? s_wstrb_i : 8'hFF;
        if (grant_wr) wdata_q <= s_wdata_i;
        if (req_oob) begin
          resp_q <= 2'b11;
          if (grant_rd) rdata_q <= '0;
        end
      end
      // Read data is returned even when the SRI flags an error.
      if (state_q == CAPTURE) begin
        resp_q <= sri_error_i ? 2'b10 : 2'b00;
        if (!type_q) rdata_q <= sri_rdata_i;
      end
    end
  end

  assign sri_addr_o  = addr_q;
  assign sri_wdata_o = wdata_q;
  assign sri_be_o    = be_q;
  assign s_bresp_o   = resp_q;
  assign s_rresp_o   = resp_q;
  assign s_rdata_o   = rdata_q;

endmodule

// File: tb/tb_riscv_dm_axil_sri_bridge.sv
// tb/tb_riscv_dm_axil_sri_bridge.sv - directed self-checking bench for riscv_dm_axil_sri_bridge.
module tb_riscv_dm_axil_sri_bridge;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic [19:0] s_awaddr_i;
  logic        s_awvalid_i, s_awready_o;
  logic [63:0] s_wdata_i;
  logic [7:0]  s_wstrb_i;
  logic        s_wvalid_i, s_wready_o;
  logic [1:0]  s_bresp_o;
  logic        s_bvalid_o, s_bready_i;
  logic [19:0] s_araddr_i;
  logic        s_arvalid_i, s_arready_o;
  logic [63:0] s_rdata_o;
  logic [1:0]  s_rresp_o;
  logic        s_rvalid_o, s_rready_i;
  logic [5:0]  sri_addr_o;
  logic        sri_en_o, sri_we_o;
  logic [63:0] sri_wdata_o;
  logic [7:0]  sri_be_o;
  logic [63:0] sri_rdata_i;
  logic        sri_error_i;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  riscv_dm_axil_sri_bridge dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .s_awaddr_i(s_awaddr_i), .s_awvalid_i(s_awvalid_i), .s_awready_o(s_awready_o),
    .s_wdata_i(s_wdata_i), .s_wstrb_i(s_wstrb_i), .s_wvalid_i(s_wvalid_i), .s_wready_o(s_wready_o),
    .s_bresp_o(s_bresp_o), .s_bvalid_o(s_bvalid_o), .s_bready_i(s_bready_i),
    .s_araddr_i(s_araddr_i), .s_arvalid_i(s_arvalid_i), .s_arready_o(s_arready_o),
    .s_rdata_o(s_rdata_o), .s_rresp_o(s_rresp_o), .s_rvalid_o(s_rvalid_o), .s_rready_i(s_rready_i),
    .sri_addr_o(sri_addr_o), .sri_en_o(sri_en_o), .sri_we_o(sri_we_o),
    .sri_wdata_o(sri_wdata_o), .sri_be_o(sri_be_o),
    .sri_rdata_i(sri_rdata_i), .sri_error_i(sri_error_i)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL timeout tests=%0d", tests);
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk_i);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input logic [19:0] a, input logic [63:0] d, input logic [7:0] s,
                          input logic err, input logic [1:0] exp_resp);
    s_awaddr_i = a; s_wdata_i = d; s_wstrb_i = s;
    s_awvalid_i = 1'b1; s_wvalid_i = 1'b1; s_bready_i = 1'b1;
    #1;
    chk("wr_awready", s_awready_o, 1);
    chk("wr_wready", s_wready_o, 1);
    step();
    s_awvalid_i = 1'b0; s_wvalid_i = 1'b0;
    chk("wr_en", sri_en_o, 1);
    chk("wr_we", sri_we_o, 1);
    chk("wr_addr", sri_addr_o, a[5:0]);
    chk("wr_be", sri_be_o, s);
    chk("wr_wdata", sri_wdata_o, d);
    sri_error_i = err;
    step();
    chk("wr_en_capture", sri_en_o, 0);
    chk("wr_bvalid_early", s_bvalid_o, 0);
    step();
    sri_error_i = 1'b0;
    chk("wr_bvalid", s_bvalid_o, 1);
    chk("wr_bresp", s_bresp_o, exp_resp);
    step();
    chk("wr_bvalid_done", s_bvalid_o, 0);
  endtask

  task automatic do_read(input logic [19:0] a, input logic [5:0] exp_addr, input logic [63:0] rd,
                         input int hold);
    s_araddr_i = a; s_arvalid_i = 1'b1; s_rready_i = 1'b0;
    #1;
    chk("rd_arready", s_arready_o, 1);
    step();
    s_arvalid_i = 1'b0;
    chk("rd_en", sri_en_o, 1);
    chk("rd_we", sri_we_o, 0);
    chk("rd_addr", sri_addr_o, exp_addr);
    chk("rd_be", sri_be_o, 8'hFF);
    sri_rdata_i = rd;
    step();
    step();
    sri_rdata_i = ~rd;
    chk("rd_rvalid", s_rvalid_o, 1);
    chk("rd_rdata", s_rdata_o, rd);
    chk("rd_rresp", s_rresp_o, 2'b00);
    for (int i = 0; i < hold; i++) begin
      step();
      chk("rd_hold_rvalid", s_rvalid_o, 1);
      chk("rd_hold_rdata", s_rdata_o, rd);
    end
    s_rready_i = 1'b1;
    step();
    s_rready_i = 1'b0;
    chk("rd_rvalid_done", s_rvalid_o, 0);
  endtask

  initial begin
    int found;
    int last_cyc;
    logic bseen;
    rstn_i = 1'b0;
    s_awaddr_i = '0; s_awvalid_i = 0; s_wdata_i = '0; s_wstrb_i = '0; s_wvalid_i = 0;
    s_bready_i = 0; s_araddr_i = '0; s_arvalid_i = 0; s_rready_i = 0;
    sri_rdata_i = '0; sri_error_i = 0;
    step(); step();
    chk("rst_en", sri_en_o, 0);
    chk("rst_we", sri_we_o, 0);
    chk("rst_valids", {s_bvalid_o, s_rvalid_o, s_awready_o, s_wready_o, s_arready_o}, 0);
    chk("rst_sri", {sri_addr_o, sri_be_o, sri_wdata_o}, 0);
    chk("rst_resp", {s_bresp_o, s_rresp_o, s_rdata_o}, 0);
    rstn_i = 1'b1;
    step();

    do_write(20'h00008, 64'h1122334455667788, 8'h0F, 1'b0, 2'b00);
    do_read(20'h00010, 6'h10, 64'hDEADBEEF00000001, 4);
    do_write(20'h00018, 64'hCAFEF00D12345678, 8'h00, 1'b1, 2'b10);

`ifdef RISCV_DM_AXIL_DECERR_EN
    s_araddr_i = 20'h00400; s_arvalid_i = 1'b1; s_rready_i = 1'b0;
    #1;
    chk("dec_arready", s_arready_o, 1);
    step();
    s_arvalid_i = 1'b0;
    chk("dec_en", sri_en_o, 0);
    chk("dec_rvalid", s_rvalid_o, 1);
    chk("dec_rresp", s_rresp_o, 2'b11);
    chk("dec_rdata", s_rdata_o, 0);
    s_rready_i = 1'b1;
    step();
    s_rready_i = 1'b0;
    chk("dec_rvalid_done", s_rvalid_o, 0);
`else
    do_read(20'h00400, 6'h00, 64'h0123456789ABCDEF, 0);
`endif

    // Reset during ACCESS abandons the write.
    s_awaddr_i = 20'h00020; s_wdata_i = 64'hA5A5A5A5A5A5A5A5; s_wstrb_i = 8'hF0;
    s_awvalid_i = 1'b1; s_wvalid_i = 1'b1; s_bready_i = 1'b1;
    step();
    s_awvalid_i = 1'b0; s_wvalid_i = 1'b0;
    chk("mid_en_before", sri_en_o, 1);
    rstn_i = 1'b0;
    #1;
    chk("mid_en_async", sri_en_o, 0);
    chk("mid_sri_async", {sri_addr_o, sri_be_o, sri_wdata_o}, 0);
    step();
    rstn_i = 1'b1;
    bseen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      bseen = bseen | s_bvalid_o | s_rvalid_o | sri_en_o;
    end
    chk("mid_no_response", bseen, 0);
    do_write(20'h00020, 64'h0F0E0D0C0B0A0908, 8'hFF, 1'b0, 2'b00);

    // Reset again so the collision starts from last_was_write = 1.
    rstn_i = 1'b0;
    step();
    rstn_i = 1'b1;
    step();
    s_araddr_i = 20'h00028; s_awaddr_i = 20'h00030; s_wdata_i = 64'h5555;
    s_wstrb_i = 8'h3C; s_arvalid_i = 1'b1; s_awvalid_i = 1'b1; s_wvalid_i = 1'b1;
    s_bready_i = 1'b1; s_rready_i = 1'b1;
    #1;
    chk("col_arready", s_arready_o, 1);
    chk("col_awready", s_awready_o, 0);
    last_cyc = 0;
    for (int k = 0; k < 4; k++) begin
      found = 0;
      for (int c = 0; c < 8 && found == 0; c++) begin
        if (sri_en_o) found = 1;
        else step();
      end
      chk("col_found", found, 1);
      chk("col_we", sri_we_o, (k % 2));
      chk("col_addr", sri_addr_o, (k % 2) ? 6'h30 : 6'h28);
      if (k > 0) chk("col_gap", cyc - last_cyc, 4);
      last_cyc = cyc;
      if (k == 3) begin
        s_arvalid_i = 1'b0; s_awvalid_i = 1'b0; s_wvalid_i = 1'b0;
      end
      step();
    end
    step();
    chk("col_last_bvalid", s_bvalid_o, 1);
    step();
    chk("col_idle", {s_bvalid_o, s_rvalid_o, sri_en_o}, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
